cache_repl_sel: RTL and testbench
=================================

Name: cache_repl_sel

Overview:
- Parameterised victim-way selector for set-associative L1 caches; successor to the single-policy random replacement unit.
- Supports random (16-bit LFSR) or per-set round-robin replacement, chosen by parameter.
- Invalid ways are always filled first; per-way lock mask excludes ways from replacement.
- Sits beside the cache tag/valid arrays; VictimWay feeds the way-select of the fill path.

Parameters:
- NUMWAYS, 4, associativity; power of two, 1..16.
- NUMSETS, 128, number of sets; power of two.
- SETLEN, $clog2(NUMSETS), set index width (derived, not overridden).
- MODE, 0, replacement policy: 0 = random LFSR, 1 = per-set round-robin.
- SEED, 16'h0001, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- FlushStage  in  1  pipeline flush; suppresses state update this cycle
- LRUWriteEn  in  1  a line fill commits this cycle; advances policy state
- InvalidateCache  in  1  whole-cache invalidate; clears round-robin pointers
- CacheSetData  in  SETLEN  set index being looked up (victim read)
- CacheSetTag  in  SETLEN  set index of the committing fill (state update)
- ValidWay  in  NUMWAYS  valid bits of looked-up set
- LockWay  in  NUMWAYS  1 = way must not be chosen
- VictimWay  out  NUMWAYS  one-hot victim, combinational from registered state and inputs
- NoVictim  out  1  all ways locked; VictimWay is 0

Behaviour:
- State:
  - MODE=0: 16-bit LFSR.
  - MODE=1: NUMSETS x log2(NUMWAYS) pointer array held in flops (not SRAM).
- Update enable: UpdEn = LRUWriteEn & ~FlushStage. No state changes when UpdEn=0.
- LFSR:
  - next = {c[0]^c[2]^c[3]^c[5], c[15:1]}, maximal length 65535.
  - Advances once per UpdEn cycle.
  - Candidate index = c[log2(NUMWAYS)-1:0].
- Round-robin:
  - On UpdEn, ptr[CacheSetTag] increments by 1, wrapping NUMWAYS-1 -> 0.
  - Candidate index = ptr[CacheSetData].
- Victim priority, evaluated each cycle:
  1. Lowest-index way with ValidWay=0 and LockWay=0.
  2. Otherwise the candidate index, if that way is unlocked.
  3. Otherwise the first unlocked way scanning upward from candidate+1, wrapping modulo NUMWAYS.
  4. Otherwise VictimWay=0 and NoVictim=1.
- An invalid-but-locked way is never chosen.
- Reset:
  - LFSR = SEED; all pointers = 0.
  - Outputs take the reset-state values in the same cycle reset is sampled, e.g. NUMWAYS=4, all valid, no locks -> VictimWay=4'b0010 (MODE=0) or 4'b0001 (MODE=1).
- Reset dominates all other inputs. Reset mid-fill discards the update.
- InvalidateCache:
  - MODE=1: clears all pointers to 0 next edge and has priority over a simultaneous UpdEn.
  - MODE=0: no effect on LFSR.
- Same-cycle update and lookup of the same set: the lookup sees the pre-update pointer (no bypass). The new value is visible the following cycle.
- Pointer update does not depend on which way was actually filled; it always increments, including when the fill used an invalid way.
- NUMWAYS=1: VictimWay = ~LockWay, NoVictim = LockWay; state logic may be removed.
- Latency: victim is combinational (0 cycles) from CacheSetData/ValidWay/LockWay; a state update is visible 1 cycle after UpdEn.

Test Plan:
- MODE=0, NUMWAYS=4, SEED=1, ValidWay=1111, LockWay=0: after reset VictimWay=0010. One UpdEn -> LFSR=16'h8000, VictimWay=0001. UpdEn with FlushStage=1 -> unchanged.
- MODE=1: three UpdEn to set 3 -> lookup set 3 gives VictimWay=1000, set 5 gives 0001. Fourth UpdEn -> set 3 wraps to 0001.
- Invalid priority: ValidWay=1011, LockWay=0 -> 0100. ValidWay=1011, LockWay=0100, set 3 ptr=0 -> 0001.
- Locking, MODE=1, ptr=2, all valid:
  - LockWay=0100 -> 1000.
  - LockWay=1100 -> 0001 (wrap).
  - LockWay=1111 -> VictimWay=0000, NoVictim=1.
- Simultaneous UpdEn and InvalidateCache on set 3 with ptr=2 -> next cycle ptr=0. Same-cycle lookup of the updated set shows the old pointer.
- Reset asserted on the same cycle as UpdEn after 10 fills -> LFSR=SEED, all pointers 0, the fill is not applied.

Source files
------------

// File: rtl/cache_repl_sel.sv
// Victim-way selector for set-associative L1 caches: fills invalid ways first and
// falls back to an LFSR (MODE=0) or per-set round-robin pointer (MODE=1), skipping locked ways.
module cache_repl_sel #(
    parameter int          NUMWAYS = 4,
    parameter int          NUMSETS = 128,
    parameter int          SETLEN  = $clog2(NUMSETS),
    parameter int          MODE    = 0,
    parameter logic [15:0] SEED    = 16'h0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStage,
    input  logic               LRUWriteEn,
    input  logic               InvalidateCache,
    input  logic [SETLEN-1:0]  CacheSetData,
    input  logic [SETLEN-1:0]  CacheSetTag,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [NUMWAYS-1:0] LockWay,
    output logic [NUMWAYS-1:0] VictimWay,
    output logic               NoVictim
);

    localparam int WAYLEN = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;

    generate
        if (NUMWAYS == 1) begin : g_one
            logic unused_one;
            assign unused_one = ^{clk, reset, FlushStage, LRUWriteEn, InvalidateCache,
                                  CacheSetData, CacheSetTag, ValidWay};
            assign VictimWay = ~LockWay;
            assign NoVictim  = LockWay[0];
        end else begin : g_multi
            logic              upd_en;
            logic [WAYLEN-1:0] cand;
            logic [WAYLEN-1:0] idx;
            logic              found;

            assign upd_en = LRUWriteEn & ~FlushStage;

            if (MODE == 0) begin : g_lfsr
                logic [15:0] lfsr;
                logic        unused_rr;
                assign unused_rr = ^{CacheSetData, CacheSetTag, InvalidateCache};

                always_ff @(posedge clk) begin
                    if (reset) begin
                        lfsr <= SEED;
                    end else if (upd_en) begin
                        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                    end
                end

                // While reset is held the victim already reflects the reset state.
                assign cand = reset ? SEED[WAYLEN-1:0] : lfsr[WAYLEN-1:0];
            end else begin : g_rr
                logic [WAYLEN-1:0] ptr [NUMSETS];

                always_ff @(posedge clk) begin
                    if (reset || InvalidateCache) begin
                        for (int s = 0; s < NUMSETS; s++) begin
                            ptr[s] <= '0;
                        end
                    end else if (upd_en) begin
                        ptr[CacheSetTag] <= ptr[CacheSetTag] + 1'b1;
                    end
                end

                // No bypass: a lookup sees the pointer before a same-cycle update.
                assign cand = reset ? '0 : ptr[CacheSetData];
            end

            always_comb begin
                VictimWay = '0;
                found     = 1'b0;
                idx       = '0;
                for (int i = 0; i < NUMWAYS; i++) begin
                    if (!found && !ValidWay[i] && !LockWay[i]) begin
                        VictimWay[i] = 1'b1;
                        found        = 1'b1;
                    end
                end
                // Scan from the candidate upward; index arithmetic wraps modulo NUMWAYS.
                for (int i = 0; i < NUMWAYS; i++) begin
                    idx = cand + WAYLEN'(i);
                    if (!found && !LockWay[idx]) begin
                        VictimWay[idx] = 1'b1;
                        found          = 1'b1;
                    end
                end
                NoVictim = ~found;
            end
        end
    endgenerate

endmodule

// File: tb/tb_cache_repl_sel.sv
// Bench for cache_repl_sel: LFSR, round-robin and single-way instances on shared stimulus,
// expectations queued on drive and compared when the outputs are sampled.
module tb_cache_repl_sel;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, FlushStage, LRUWriteEn, InvalidateCache;
    logic [2:0] CacheSetData, CacheSetTag;
    logic [3:0] ValidWay, LockWay;
    logic [3:0] vw0, vw1;
    logic       nv0, nv1, vw2, nv2;

    cache_repl_sel #(.NUMWAYS(4), .NUMSETS(8), .MODE(0), .SEED(16'h0001)) u0 (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .LRUWriteEn(LRUWriteEn),
        .InvalidateCache(InvalidateCache), .CacheSetData(CacheSetData), .CacheSetTag(CacheSetTag),
        .ValidWay(ValidWay), .LockWay(LockWay), .VictimWay(vw0), .NoVictim(nv0));

    cache_repl_sel #(.NUMWAYS(4), .NUMSETS(8), .MODE(1), .SEED(16'h0001)) u1 (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .LRUWriteEn(LRUWriteEn),
        .InvalidateCache(InvalidateCache), .CacheSetData(CacheSetData), .CacheSetTag(CacheSetTag),
        .ValidWay(ValidWay), .LockWay(LockWay), .VictimWay(vw1), .NoVictim(nv1));

    cache_repl_sel #(.NUMWAYS(1), .NUMSETS(8), .MODE(1), .SEED(16'h0001)) u2 (
        .clk(clk), .reset(reset), .FlushStage(FlushStage), .LRUWriteEn(LRUWriteEn),
        .InvalidateCache(InvalidateCache), .CacheSetData(CacheSetData), .CacheSetTag(CacheSetTag),
        .ValidWay(ValidWay[0]), .LockWay(LockWay[0]), .VictimWay(vw2), .NoVictim(nv2));

    typedef struct {
        string      name;
        int         dut;
        logic [3:0] vw;
        logic       nv;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [15:0] lfsr_m;
    logic [1:0]  ptr_m [8];

    task automatic drive(input logic r, u, f, inv, input logic [2:0] d, t,
                         input logic [3:0] v, l);
        reset = r; LRUWriteEn = u; FlushStage = f; InvalidateCache = inv;
        CacheSetData = d; CacheSetTag = t; ValidWay = v; LockWay = l;
    endtask

    // Consume the driven inputs at the next edge and advance the reference state.
    task automatic commit();
        @(posedge clk);
        if (reset) begin
            lfsr_m = 16'h0001;
            for (int s = 0; s < 8; s++) ptr_m[s] = 2'd0;
        end else begin
            if (LRUWriteEn && !FlushStage)
                lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
            if (InvalidateCache)
                for (int s = 0; s < 8; s++) ptr_m[s] = 2'd0;
            else if (LRUWriteEn && !FlushStage)
                ptr_m[CacheSetTag] = ptr_m[CacheSetTag] + 2'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        exp_t e; logic [3:0] av; logic an;
        for (int k = 0; k < 2; k++) begin
            drive(k == 0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'hF, 4'h0);
            sb.push_back('{"reset_lfsr", 0, 4'b0010, 1'b0});
            sb.push_back('{"reset_rr", 1, 4'b0001, 1'b0});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = (e.dut == 0) ? vw0 : vw1;
                an = (e.dut == 0) ? nv0 : nv1;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s: dut%0d VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, e.dut, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    task automatic test_lfsr();
        exp_t e; logic [3:0] av; logic an;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, k < 10, k == 4, 1'b0, 3'd7, 3'd7, 4'hF, 4'h0);
            if (k == 1) sb.push_back('{"lfsr_first_step", 0, 4'b0001, 1'b0});
            sb.push_back('{"lfsr_seq", 0, 4'b0001 << lfsr_m[1:0], 1'b0});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = vw0; an = nv0;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s(step %0d): VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, k, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    task automatic test_round_robin();
        exp_t e; logic [3:0] av; logic an;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'hF, 4'h0);
        commit();
        for (int k = 0; k < 7; k++) begin
            case (k)
                0, 1, 2: begin
                    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'h0);
                    sb.push_back('{"rr_fill", 1, 4'b0001 << ptr_m[3], 1'b0});
                end
                3: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'h0);
                    sb.push_back('{"rr_set3_after3", 1, 4'b1000, 1'b0});
                end
                4: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd3, 4'hF, 4'h0);
                    sb.push_back('{"rr_set5_untouched", 1, 4'b0001, 1'b0});
                end
                5: drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 3'd3, 4'hF, 4'h0);
                default: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'h0);
                    sb.push_back('{"rr_set3_wrap", 1, 4'b0001, 1'b0});
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = vw1; an = nv1;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s: VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    task automatic test_invalid_and_lock();
        exp_t e; logic [3:0] av; logic an;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'b1011, 4'b0000);
                    sb.push_back('{"inv_first_lfsr", 0, 4'b0100, 1'b0});
                    sb.push_back('{"inv_first_rr", 1, 4'b0100, 1'b0});
                end
                1: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'b1011, 4'b0100);
                    sb.push_back('{"inv_locked_cand", 1, 4'b0001, 1'b0});
                end
                2: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'b1110, 4'b0001);
                    sb.push_back('{"inv_locked_skip", 1, 4'b0010, 1'b0});
                end
                3, 4: begin
                    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'h0);
                    sb.push_back('{"lock_prep_fill", 1, 4'b0001 << ptr_m[3], 1'b0});
                end
                5: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'b0100);
                    sb.push_back('{"lock_next", 1, 4'b1000, 1'b0});
                end
                6: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'b1100);
                    sb.push_back('{"lock_wrap", 1, 4'b0001, 1'b0});
                end
                default: begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 4'hF, 4'b1111);
                    sb.push_back('{"all_locked_lfsr", 0, 4'b0000, 1'b1});
                    sb.push_back('{"all_locked_rr", 1, 4'b0000, 1'b1});
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = (e.dut == 0) ? vw0 : vw1;
                an = (e.dut == 0) ? nv0 : nv1;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s: dut%0d VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, e.dut, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    task automatic test_invalidate();
        exp_t e; logic [3:0] av; logic an;
        for (int k = 0; k < 4; k++) begin
            // Row 0: fill + invalidate on set 3 (ptr 2); row 2: invalidate alone.
            drive(1'b0, k == 0, 1'b0, k == 0 || k == 2, 3'd3, 3'd3, 4'hF, 4'h0);
            sb.push_back('{"inval_lfsr", 0, 4'b0001 << lfsr_m[1:0], 1'b0});
            if (k == 0) sb.push_back('{"inval_same_cycle_old_ptr", 1, 4'b0100, 1'b0});
            else        sb.push_back('{"inval_cleared", 1, 4'b0001, 1'b0});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = (e.dut == 0) ? vw0 : vw1;
                an = (e.dut == 0) ? nv0 : nv1;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s: dut%0d VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, e.dut, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [3:0] av; logic an;
        for (int k = 0; k < 14; k++) begin
            if (k < 10) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 4'hF, 4'h0);
                sb.push_back('{"b2b_fill", 1, 4'b0001 << ptr_m[2], 1'b0});
                sb.push_back('{"b2b_lfsr", 0, 4'b0001 << lfsr_m[1:0], 1'b0});
            end else if (k == 10) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 4'hF, 4'h0);
                sb.push_back('{"rst_fill_lfsr", 0, 4'b0010, 1'b0});
                sb.push_back('{"rst_fill_rr", 1, 4'b0001, 1'b0});
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, (k == 12) ? 3'd3 : 3'd2, 3'd2, 4'hF, 4'h0);
                sb.push_back('{"after_rst_lfsr", 0, 4'b0010, 1'b0});
                sb.push_back('{"after_rst_rr", 1, 4'b0001, 1'b0});
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = (e.dut == 0) ? vw0 : vw1;
                an = (e.dut == 0) ? nv0 : nv1;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s(step %0d): dut%0d VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, k, e.dut, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    task automatic test_one_way();
        exp_t e; logic [3:0] av; logic an;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 4'hF, {3'b000, k == 1});
            sb.push_back('{"one_way", 2, (k == 1) ? 4'b0000 : 4'b0001, k == 1});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                av = {3'b000, vw2}; an = nv2;
                n_checks++;
                if (av !== e.vw || an !== e.nv) begin
                    n_fail++;
                    $display("FAIL %s(lock=%0d): VictimWay=%b NoVictim=%b, expected %b/%b",
                             e.name, k, av, an, e.vw, e.nv);
                end
            end
            commit();
        end
    endtask

    initial begin
        lfsr_m = 16'h0001;
        for (int s = 0; s < 8; s++) ptr_m[s] = 2'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'hF, 4'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_lfsr();
        test_round_robin();
        test_invalid_and_lock();
        test_invalidate();
        test_back_to_back();
        test_one_way();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
